// File: rtl/simd_sequencer.sv
// Start/done-controlled fetch/execute sequencer for the SIMD processor.
// Fetches from synchronous instruction memory and strobes the datapath once per datapath opcode.
module simd_sequencer #(
  parameter int unsigned INS_ADDR_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned OPCODE_WIDTH   = 3
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [INS_ADDR_WIDTH-1:0]            start_pc,
  input  logic                                 abort,
  input  logic                                 stall,
  input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] instruction,
  output logic [INS_ADDR_WIDTH-1:0]            pc,
  output logic                                 ins_rd_en,
  output logic                                 issue,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overrun,
  output logic                                 loop_active
);

  localparam logic [OPCODE_WIDTH-1:0]   OpLoop = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0]   OpHalt = OPCODE_WIDTH'(7);
  localparam logic [INS_ADDR_WIDTH-1:0] LastPc = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  state_e                    state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                      overrun_q, overrun_d;
  logic                      loop_active_q, loop_active_d;
  logic [ADDR_WIDTH-1:0]     loop_cnt_q, loop_cnt_d;

  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [ADDR_WIDTH-1:0]     r_field;
  logic [ADDR_WIDTH-1:0]     b_field;
  logic [ADDR_WIDTH-1:0]     a_field;
  logic [INS_ADDR_WIDTH-1:0] loop_target;
  logic                      is_loop;
  logic                      is_halt;
  logic                      at_last;
  logic                      loop_taken;
  logic                      advance;
  logic                      unused_fields;

  assign opcode      = instruction[OPCODE_WIDTH-1:0];
  assign r_field     = instruction[OPCODE_WIDTH +: ADDR_WIDTH];
  assign b_field     = instruction[OPCODE_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
  assign a_field     = instruction[OPCODE_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];
  assign loop_target = r_field[INS_ADDR_WIDTH-1:0];
  assign is_loop     = (opcode == OpLoop);
  assign is_halt     = (opcode == OpHalt);
  assign at_last     = (pc_q == LastPc);

  // The B field and upper target bits belong to the datapath decoder, not to the sequencer.
  assign unused_fields = ^{b_field, r_field};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      overrun_q     <= 1'b0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      overrun_q     <= overrun_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    overrun_d     = overrun_q;
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
    ins_rd_en     = 1'b0;
    issue         = 1'b0;
    loop_taken    = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d          = start_pc;
          overrun_d     = 1'b0;
          loop_active_d = 1'b0;
          state_d       = StFetch;
        end
      end
      StFetch: begin
        ins_rd_en = 1'b1;
        state_d   = StExec;
      end
      StExec: begin
        if (is_halt) begin
          state_d = StDone;
        end else if (is_loop) begin
          if (!loop_active_q) begin
            if (a_field != '0) begin
              loop_active_d = 1'b1;
              loop_cnt_d    = a_field - ADDR_WIDTH'(1);
              loop_taken    = 1'b1;
            end
          end else if (loop_cnt_q != '0) begin
            loop_cnt_d = loop_cnt_q - ADDR_WIDTH'(1);
            loop_taken = 1'b1;
          end else begin
            loop_active_d = 1'b0;
          end
          if (loop_taken) begin
            pc_d    = loop_target;
            state_d = StFetch;
          end else begin
            advance = 1'b1;
          end
        end else if (!stall) begin
          issue   = 1'b1;
          advance = 1'b1;
        end
        // No wrap past the top of instruction memory: flag it and finish instead.
        if (advance) begin
          if (at_last) begin
            overrun_d = 1'b1;
            state_d   = StDone;
          end else begin
            pc_d    = pc_q + INS_ADDR_WIDTH'(1);
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d       = StIdle;
      pc_d          = pc_q;
      overrun_d     = overrun_q;
      loop_cnt_d    = loop_cnt_q;
      loop_active_d = 1'b0;
      ins_rd_en     = 1'b0;
      issue         = 1'b0;
    end
  end

  assign pc          = pc_q;
  assign busy        = (state_q == StFetch) || (state_q == StExec);
  assign done        = (state_q == StDone);
  assign overrun     = overrun_q;
  assign loop_active = loop_active_q;

endmodule

// File: tb/tb_simd_sequencer.sv
// Directed bench for simd_sequencer: small instruction memory model, per-cycle capture
// of strobes relative to the start cycle, and hand-computed expected cycle masks.
module tb_simd_sequencer;
  localparam int IAW = 3;
  localparam int AW  = 10;
  localparam int OW  = 3;
  localparam int IW  = OW + 3 * AW;

  localparam logic [OW-1:0] OpAdd  = 3'd0;
  localparam logic [OW-1:0] OpSub  = 3'd1;
  localparam logic [OW-1:0] OpMul  = 3'd2;
  localparam logic [OW-1:0] OpLoop = 3'd6;
  localparam logic [OW-1:0] OpHalt = 3'd7;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [IAW-1:0] start_pc = '0;
  logic           abort = 1'b0;
  logic           stall = 1'b0;
  logic [IW-1:0]  instruction = '0;
  logic [IAW-1:0] pc;
  logic           ins_rd_en, issue, busy, done, overrun, loop_active;

  logic [IW-1:0]  mem [2**IAW];
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;

  logic [63:0]    issue_m, done_m, busy_m, rd_m, la_m;
  logic           pc0_seen, ovr_first, ovr_last;

  simd_sequencer #(
    .INS_ADDR_WIDTH(IAW),
    .ADDR_WIDTH    (AW),
    .OPCODE_WIDTH  (OW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .start_pc   (start_pc),
    .abort      (abort),
    .stall      (stall),
    .instruction(instruction),
    .pc         (pc),
    .ins_rd_en  (ins_rd_en),
    .issue      (issue),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .loop_active(loop_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ins_rd_en) instruction <= mem[pc];

  function automatic logic [IW-1:0] ins(input logic [OW-1:0] op, input logic [AW-1:0] a,
                                        input logic [AW-1:0] r);
    return {a, 10'd0, r, op};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 2**IAW; i++) mem[i] = ins(OpHalt, '0, '0);
  endtask

  task automatic load_straight();
    fill_halt();
    mem[0] = ins(OpAdd, 10'd1, 10'd2);
    mem[1] = ins(OpSub, 10'd3, 10'd4);
    mem[2] = ins(OpMul, 10'd5, 10'd6);
    mem[5] = ins(OpAdd, 10'd0, 10'd0);
    mem[6] = ins(OpAdd, 10'd0, 10'd0);
  endtask

  task automatic load_loop(input logic [AW-1:0] n);
    fill_halt();
    mem[0] = ins(OpAdd, 10'd1, 10'd2);
    // Target field has a bit above the 3-bit address range; target is still 0.
    mem[1] = ins(OpLoop, n, 10'h008);
  endtask

  // Start at cycle T (rel 0), then capture outputs for rel 1..max_cyc at the negedge.
  task automatic run_prog(input logic [IAW-1:0] spc, input int st_lo, input int st_hi,
                          input int ab_at, input int s2_at, input logic [IAW-1:0] s2pc,
                          input int max_cyc);
    issue_m = '0; done_m = '0; busy_m = '0; rd_m = '0; la_m = '0;
    pc0_seen = 1'b0; ovr_first = 1'b0; ovr_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    start_pc = spc;
    for (int rel = 1; rel <= max_cyc; rel++) begin
      @(posedge clk); #1;
      start = (rel == s2_at);
      if (rel == s2_at) start_pc = s2pc;
      stall = (rel >= st_lo) && (rel <= st_hi);
      abort = (rel == ab_at);
      @(negedge clk);
      if (issue)       issue_m[rel] = 1'b1;
      if (done)        done_m[rel]  = 1'b1;
      if (busy)        busy_m[rel]  = 1'b1;
      if (ins_rd_en)   rd_m[rel]    = 1'b1;
      if (loop_active) la_m[rel]    = 1'b1;
      if (pc == '0)    pc0_seen     = 1'b1;
      if (rel == 1)    ovr_first    = overrun;
      ovr_last = overrun;
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc !== '0) begin
      errors++; $display("FAIL reset_pc: got %0d want 0", pc);
    end
    checks++;
    if ({ins_rd_en, issue, busy, done, overrun, loop_active} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {ins_rd_en, issue, busy, done, overrun, loop_active});
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_start: busy got %b want 0", busy);
    end
  endtask

  task automatic test_straight();
    load_straight();
    run_prog(3'd0, -1, -1, -1, -1, 3'd0, 14);
    checks++;
    if (issue_m !== 64'h54) begin
      errors++; $display("FAIL straight_issue: got %h want %h", issue_m, 64'h54);
    end
    checks++;
    if (done_m !== 64'h200) begin
      errors++; $display("FAIL straight_done: got %h want %h", done_m, 64'h200);
    end
    checks++;
    if (busy_m !== 64'h1FE) begin
      errors++; $display("FAIL straight_busy: got %h want %h", busy_m, 64'h1FE);
    end
    checks++;
    if (rd_m !== 64'hAA) begin
      errors++; $display("FAIL straight_rd_en: got %h want %h", rd_m, 64'hAA);
    end
    checks++;
    if (ovr_last !== 1'b0) begin
      errors++; $display("FAIL straight_overrun: got %b want 0", ovr_last);
    end
  endtask

  task automatic test_stall();
    load_straight();
    run_prog(3'd0, 4, 6, -1, -1, 3'd0, 16);
    checks++;
    if (issue_m !== 64'h284) begin
      errors++; $display("FAIL stall_issue: got %h want %h", issue_m, 64'h284);
    end
    checks++;
    if (done_m !== 64'h1000) begin
      errors++; $display("FAIL stall_done: got %h want %h", done_m, 64'h1000);
    end
    checks++;
    if (rd_m !== 64'h50A) begin
      errors++; $display("FAIL stall_rd_en: got %h want %h", rd_m, 64'h50A);
    end
  endtask

  task automatic test_loop();
    load_loop(10'd2);
    run_prog(3'd0, -1, -1, -1, -1, 3'd0, 20);
    checks++;
    if (issue_m !== 64'h444) begin
      errors++; $display("FAIL loop2_issue: got %h want %h", issue_m, 64'h444);
    end
    checks++;
    if (la_m !== 64'h1FE0) begin
      errors++; $display("FAIL loop2_active: got %h want %h", la_m, 64'h1FE0);
    end
    checks++;
    if (done_m !== 64'h8000) begin
      errors++; $display("FAIL loop2_done: got %h want %h", done_m, 64'h8000);
    end
    // N=0 falls through; stall during the LOOP exec must not hold it.
    load_loop(10'd0);
    run_prog(3'd0, 4, 4, -1, -1, 3'd0, 12);
    checks++;
    if (issue_m !== 64'h4) begin
      errors++; $display("FAIL loop0_issue: got %h want %h", issue_m, 64'h4);
    end
    checks++;
    if (la_m !== 64'h0) begin
      errors++; $display("FAIL loop0_active: got %h want 0", la_m);
    end
    checks++;
    if (done_m !== 64'h80) begin
      errors++; $display("FAIL loop0_done: got %h want %h", done_m, 64'h80);
    end
  endtask

  task automatic test_overrun();
    fill_halt();
    mem[6] = ins(OpAdd, 10'd1, 10'd1);
    mem[7] = ins(OpAdd, 10'd2, 10'd2);
    run_prog(3'd6, -1, -1, -1, -1, 3'd0, 10);
    checks++;
    if (issue_m !== 64'h14) begin
      errors++; $display("FAIL overrun_issue: got %h want %h", issue_m, 64'h14);
    end
    checks++;
    if (done_m !== 64'h20) begin
      errors++; $display("FAIL overrun_done: got %h want %h", done_m, 64'h20);
    end
    checks++;
    if (ovr_last !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b want 1", ovr_last);
    end
    checks++;
    if (pc0_seen !== 1'b0) begin
      errors++; $display("FAIL overrun_no_wrap: pc zero seen %b want 0", pc0_seen);
    end
    run_prog(3'd0, -1, -1, -1, -1, 3'd0, 6);
    checks++;
    if (ovr_first !== 1'b0) begin
      errors++; $display("FAIL overrun_clear: got %b want 0", ovr_first);
    end
    checks++;
    if (done_m !== 64'h8) begin
      errors++; $display("FAIL overrun_restart_done: got %h want %h", done_m, 64'h8);
    end
  endtask

  task automatic test_abort();
    load_straight();
    run_prog(3'd0, -1, -1, 4, -1, 3'd0, 12);
    checks++;
    if (issue_m !== 64'h4) begin
      errors++; $display("FAIL abort_issue: got %h want %h", issue_m, 64'h4);
    end
    checks++;
    if (busy_m !== 64'h1E) begin
      errors++; $display("FAIL abort_busy: got %h want %h", busy_m, 64'h1E);
    end
    checks++;
    if (done_m !== 64'h0) begin
      errors++; $display("FAIL abort_done: got %h want 0", done_m);
    end
    checks++;
    if (rd_m !== 64'hA) begin
      errors++; $display("FAIL abort_rd_en: got %h want %h", rd_m, 64'hA);
    end
  endtask

  task automatic test_reset_mid_loop();
    load_loop(10'd2);
    run_prog(3'd0, -1, -1, -1, -1, 3'd0, 8);
    checks++;
    if (loop_active !== 1'b1 || pc !== 3'd1) begin
      errors++;
      $display("FAIL midloop_precond: loop_active %b pc %0d want 1 and 1", loop_active, pc);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({pc, ins_rd_en, issue, busy, done, overrun, loop_active} !== '0) begin
      errors++;
      $display("FAIL midloop_reset: pc %0d flags %b want 0 and 000000", pc,
               {ins_rd_en, issue, busy, done, overrun, loop_active});
    end
    rstn = 1'b1;
    done_m = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_m[i] = 1'b1;
    end
    checks++;
    if (done_m !== 64'h0) begin
      errors++; $display("FAIL midloop_no_done: got %h want 0", done_m);
    end
  endtask

  task automatic test_start_while_busy();
    load_straight();
    run_prog(3'd0, -1, -1, -1, 3, 3'd5, 14);
    checks++;
    if (issue_m !== 64'h54) begin
      errors++; $display("FAIL busy_start_issue: got %h want %h", issue_m, 64'h54);
    end
    checks++;
    if (done_m !== 64'h200) begin
      errors++; $display("FAIL busy_start_done: got %h want %h", done_m, 64'h200);
    end
  endtask

  task automatic test_back_to_back();
    load_straight();
    // Start during DONE is ignored.
    run_prog(3'd0, -1, -1, -1, 9, 3'd0, 22);
    checks++;
    if (issue_m !== 64'h54 || done_m !== 64'h200) begin
      errors++;
      $display("FAIL b2b_start_in_done: issue %h done %h want %h %h", issue_m, done_m,
               64'h54, 64'h200);
    end
    // Start two cycles after HALT exec is accepted.
    run_prog(3'd0, -1, -1, -1, 10, 3'd0, 22);
    checks++;
    if (issue_m !== 64'h15054) begin
      errors++; $display("FAIL b2b_issue: got %h want %h", issue_m, 64'h15054);
    end
    checks++;
    if (done_m !== 64'h80200) begin
      errors++; $display("FAIL b2b_done: got %h want %h", done_m, 64'h80200);
    end
  endtask

  initial begin
    fill_halt();
    test_reset();
    test_straight();
    test_stall();
    test_loop();
    test_overrun();
    test_abort();
    test_reset_mid_loop();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_sequencer.md
# simd_sequencer

Program sequencer for the SIMD processor. It replaces the free-running program counter and `half_clk` strobe with a start/done-controlled fetch/execute loop. It fetches instructions from the synchronous instruction memory and strobes the decoder/datapath once per datapath instruction. It also supports a stall input, one hardware loop, a HALT opcode and an abort.

## Interface
- `INS_ADDR_WIDTH`, default 10: instruction memory address width.
- `ADDR_WIDTH`, default 10: data-address field width in the instruction word.
- `OPCODE_WIDTH`, default 3: opcode field width.
- `clk` input, 1 bit: clock.
- `rstn` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: start pulse. Sampled only in IDLE.
- `start_pc` input, INS_ADDR_WIDTH bits: first instruction address, captured with `start`.
- `abort` input, 1 bit: terminates the program immediately.
- `stall` input, 1 bit: datapath not ready (dot-product/BRAM busy). Holds EXEC.
- `instruction` input, OPCODE_WIDTH+3*ADDR_WIDTH bits: instruction memory read data, valid one cycle after `ins_rd_en`. Field layout:
  - `[OPCODE_WIDTH-1:0]` opcode
  - next ADDR_WIDTH bits: R field
  - next ADDR_WIDTH bits: B field
  - top ADDR_WIDTH bits: A field
- `pc` output, INS_ADDR_WIDTH bits: instruction memory address.
- `ins_rd_en` output, 1 bit: instruction memory read enable.
- `issue` output, 1 bit: one-cycle execute strobe to the decoder/datapath, in place of `half_clk`.
- `busy` output, 1 bit: program running.
- `done` output, 1 bit: one-cycle pulse on normal completion.
- `overrun` output, 1 bit: sticky flag; the program ran past the last address without HALT. Cleared by `start`.
- `loop_active` output, 1 bit: hardware loop in progress.

## Operation
- **States**
  - IDLE: `busy`=0.
  - FETCH: `ins_rd_en`=1, `pc` driven with the current address.
  - EXEC: `instruction` is valid; evaluate it.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- **IDLE**
  - `start`=1: `pc`<=`start_pc`, clear `overrun`, `loop_active`<=0, go to FETCH.
  - `start` while not in IDLE is ignored.
- **FETCH**: always goes to EXEC next cycle.
- **EXEC, opcodes 000–101 (datapath)**
  - If `stall`=1: `issue`=0, remain in EXEC. The instruction memory output is held by not re-asserting `ins_rd_en`.
  - If `stall`=0: `issue`=1 for this cycle, `pc`<=`pc`+1, go to FETCH.
- **EXEC, opcode 110 (LOOP)**: A field = count N (low INS_ADDR_WIDTH bits are not truncated; full ADDR_WIDTH counter). R field low INS_ADDR_WIDTH bits = target address. `issue`=0; `stall` is ignored.
  - `loop_active`=0 and N=0: fall through, `pc`<=`pc`+1.
  - `loop_active`=0 and N>0: `loop_active`<=1, `loop_cnt`<=N-1, `pc`<=target.
  - `loop_active`=1 and `loop_cnt`=0: `loop_active`<=0, `pc`<=`pc`+1.
  - `loop_active`=1 and `loop_cnt`>0: `loop_cnt`<=`loop_cnt`-1, `pc`<=target.
  - Net effect: the loop body executes N+1 times. Nesting is unsupported; an inner LOOP shares the single counter.
- **EXEC, opcode 111 (HALT)**: `issue`=0, go to DONE. `pc` is not incremented.
- **Last address**: in EXEC at `pc` = 2^INS_ADDR_WIDTH-1 with a non-HALT, non-taken instruction, set `overrun`=1 and go to DONE. No wrap to 0. A datapath instruction there still issues, unless stalled.
- **Abort**: `abort`=1 in any non-IDLE state has priority over everything. `issue` and `ins_rd_en` are forced to 0 that cycle. Next state is IDLE, with no `done` pulse and `loop_active`<=0.
- **Reset**: all outputs 0 (`pc`=0, `ins_rd_en`=0, `issue`=0, `busy`=0, `done`=0, `overrun`=0, `loop_active`=0). State = IDLE, `loop_cnt`=0. Reset mid-program discards the program with no `done`.

## Timing
- With `start` sampled at cycle T:
  - FETCH of `start_pc` at T+1.
  - EXEC at T+2.
  - Each unstalled instruction takes 2 cycles, so `issue` has at most 50% duty, matching the datapath's 2-cycle execute.
- Each stall cycle adds one cycle; `issue` rises in the first EXEC cycle with `stall`=0.
- `busy`=1 in FETCH and EXEC. It is 0 in IDLE and DONE, so `busy` falls in the same cycle `done` pulses.
- HALT executed at cycle E: `done` at E+1, IDLE at E+2. A new `start` is accepted from E+2.
- All outputs are registered or derived from state only; there is no combinational path from `stall`/`start` to `pc`. The exceptions are `issue` (combinational from state, opcode and `stall`) and the `abort` gating of `issue` and `ins_rd_en`.

## Test plan
- **Straight-line program**: addr 0..2 = ADD/SUB/MUL, addr 3 = HALT; `start_pc`=0 at T. Required: `issue` at T+2, T+4, T+6; `done` at T+9; `busy` high T+1..T+8; `overrun`=0.
- **Stall**: same program with `stall`=1 during T+4..T+6. Required: second `issue` at T+7; `done` at T+12.
- **Loop**: addr 0 = ADD, addr 1 = LOOP with N=2 and target 0, addr 2 = HALT. Required: exactly 3 `issue` pulses; `loop_active` high from the first LOOP exec until the third; `done` follows. Repeat with N=0: 1 `issue`.
- **Overrun**: INS_ADDR_WIDTH=3, `start_pc`=6, addr 6 and 7 = ADD, no HALT. Required: 2 `issue` pulses, `overrun`=1, `done` pulse, `pc` never reads 0 after start. Next `start` clears `overrun`.
- **Abort/reset**: `abort` asserted in the EXEC of the second instruction. Required: no `issue` that cycle, IDLE next cycle, no `done`. Separately, `rstn`=0 mid-loop clears all outputs to 0 the next cycle.
- **Start while busy**: `start` pulsed at T+3 with a different `start_pc`. Required: ignored; the program completes unchanged.
